// File: rtl/mem_access_stage.sv
// RISC-V MEM stage: load/store over a req/ack data-memory handshake, load alignment/extension,
// pipeline stall while an access is in flight. Optional BUSY timeout guarded by `MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic        reg_w_i,
  input  logic [4:0]  reg_d_i,
  output logic [31:0] data_to_reg_o,
  output logic        reg_w_o,
  output logic [4:0]  reg_d_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        acc;
  logic        misaligned;
  logic        start;
  logic [1:0]  size;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;

  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        reg_w_q;
  logic [4:0]  reg_d_q;
  logic [31:0] load_q;
  logic [31:0] load_ext;
  logic        bus_err;
  logic        timeout_hit;

  assign acc = valid_i & (mem_read_i | mem_write_i);

  // Stores only know SB/SH/SW; loads also have the unsigned byte/half forms. Anything else is a word.
  always_comb begin
    size = SZ_WORD;
    if (mem_write_i) begin
      if (funct3_i == 3'b000)      size = SZ_BYTE;
      else if (funct3_i == 3'b001) size = SZ_HALF;
    end else begin
      if (funct3_i[1:0] == 2'b00)      size = SZ_BYTE;
      else if (funct3_i[1:0] == 2'b01) size = SZ_HALF;
    end
  end

  assign misaligned = ((size == SZ_HALF) & alu_result_i[0]) |
                      ((size == SZ_WORD) & (|alu_result_i[1:0]));
  assign start      = (state_q == S_IDLE) & acc & ~misaligned;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    be_new    = 4'b1111;
    wdata_new = store_data_i;
    if (mem_write_i) begin
      case (size)
        SZ_BYTE: begin
          be_new    = 4'b0001 << alu_result_i[1:0];
          wdata_new = {4{store_data_i[7:0]}};
        end
        SZ_HALF: begin
          be_new    = alu_result_i[1] ? 4'b1100 : 4'b0011;
          wdata_new = {2{store_data_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Lane selection and extension use the offset and funct3 frozen at issue time.
  always_comb begin
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    sel_b = 8'(dmem_rdata_i >> {off_q, 3'b000});
    sel_h = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{sel_b[7]}}, sel_b};
      3'b100:  load_ext = {24'd0, sel_b};
      3'b001:  load_ext = {{16{sel_h[15]}}, sel_h};
      3'b101:  load_ext = {16'd0, sel_h};
      default: load_ext = dmem_rdata_i;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;

  assign timeout_hit = (state_q == S_BUSY) & ~dmem_ack_i &
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d     = cnt_q;
    bus_err_d = 1'b0;
    if (start)                     cnt_d = CNT_W'(1);
    else if (state_q == S_BUSY)    cnt_d = cnt_q + CNT_W'(1);
    if (timeout_hit)               bus_err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  assign bus_err_o = bus_err;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BUSY;
      S_BUSY:  if (dmem_ack_i || timeout_hit) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      reg_w_q <= 1'b0;
      reg_d_q <= '0;
      load_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      if (start) begin
        addr_q  <= {alu_result_i[31:2], 2'b00};
        be_q    <= be_new;
        wdata_q <= wdata_new;
        we_q    <= mem_write_i;
        f3_q    <= funct3_i;
        off_q   <= alu_result_i[1:0];
        reg_w_q <= reg_w_i;
        reg_d_q <= reg_d_i;
      end
      if (state_q == S_BUSY && dmem_ack_i) load_q <= load_ext;
    end
  end

  assign dmem_req_o   = (state_q == S_BUSY);
  assign dmem_we_o    = we_q & dmem_req_o;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

  // IDLE outputs are gated by reset so an instruction held upstream cannot raise stall during reset.
  always_comb begin
    data_to_reg_o = alu_result_i;
    reg_w_o       = 1'b0;
    reg_d_o       = reg_d_i;
    stall_o       = 1'b0;
    misalign_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (reset_i) begin
          if (acc) begin
            misalign_o = misaligned;
            stall_o    = ~misaligned;
          end else begin
            reg_w_o = reg_w_i & valid_i;
          end
        end
      end
      S_BUSY: begin
        stall_o       = 1'b1;
        data_to_reg_o = load_q;
        reg_d_o       = reg_d_q;
      end
      default: begin
        data_to_reg_o = load_q;
        reg_w_o       = reg_w_q & ~we_q & ~bus_err;
        reg_d_o       = reg_d_q;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; the timeout scenario runs only when
// MEM_TIMEOUT_EN is defined (built with TIMEOUT_CYCLES=8).
module tb_mem_access_stage;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic [31:0] alu_result_i;
  logic [31:0] store_data_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  funct3_i;
  logic        reg_w_i;
  logic [4:0]  reg_d_i;
  logic [31:0] data_to_reg_o;
  logic        reg_w_o;
  logic [4:0]  reg_d_o;
  logic        stall_o;
  logic        misalign_o;
  logic        bus_err_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .valid_i      (valid_i),
    .alu_result_i (alu_result_i),
    .store_data_i (store_data_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .funct3_i     (funct3_i),
    .reg_w_i      (reg_w_i),
    .reg_d_i      (reg_d_i),
    .data_to_reg_o(data_to_reg_o),
    .reg_w_o      (reg_w_o),
    .reg_d_o      (reg_d_o),
    .stall_o      (stall_o),
    .misalign_o   (misalign_o),
    .bus_err_o    (bus_err_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_rdata_i (dmem_rdata_i),
    .dmem_ack_i   (dmem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_nop();
    valid_i      = 1'b0;
    alu_result_i = '0;
    store_data_i = '0;
    mem_read_i   = 1'b0;
    mem_write_i  = 1'b0;
    funct3_i     = '0;
    reg_w_i      = 1'b0;
    reg_d_i      = '0;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = '0;
  endtask

  // Holds one memory instruction upstream until the DONE cycle; acks on BUSY cycle ack_on (0 = never).
  task automatic do_access(input logic [2:0] f3, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] sd,
                           input logic [31:0] rdata, input int ack_on,
                           output int n_stall, output int n_busy,
                           output logic [31:0] q_addr, output logic [31:0] q_wdata,
                           output logic [3:0] q_be, output logic q_we,
                           output logic [31:0] d_data, output logic d_regw,
                           output logic [4:0] d_rd, output logic d_err);
    bit done;
    done = 1'b0;
    n_stall = 0; n_busy = 0;
    q_addr = '0; q_wdata = '0; q_be = '0; q_we = 1'b0;
    d_data = '0; d_regw = 1'b0; d_rd = '0; d_err = 1'b0;
    @(negedge clk_i);
    valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
    alu_result_i = addr; store_data_i = sd; reg_w_i = 1'b1; reg_d_i = 5'd9;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      #1;
      if (dmem_req_o) begin
        n_busy++;
        if (n_busy == 1) begin
          q_addr = dmem_addr_o; q_wdata = dmem_wdata_o; q_be = dmem_be_o; q_we = dmem_we_o;
        end
        dmem_ack_i   = (n_busy == ack_on);
        dmem_rdata_i = rdata;
      end
      if (stall_o) n_stall++;
      else if (cyc > 0) begin
        d_data = data_to_reg_o; d_regw = reg_w_o; d_rd = reg_d_o; d_err = bus_err_o;
        done = 1'b1;
      end
      @(negedge clk_i);
      dmem_ack_i = 1'b0;
    end
    check("access_completed", 32'(done), 32'd1);
    drive_nop();
  endtask

  int          ns, nb;
  logic [31:0] qa, qw, dd;
  logic [3:0]  qb;
  logic        qwe, drw, der;
  logic [4:0]  drd;

  initial begin
    drive_nop();
    reset_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_req", 32'(dmem_req_o), 0);
    check("rst_addr", dmem_addr_o, 0);
    check("rst_be_we_err", {27'd0, dmem_be_o, dmem_we_o}, 0);
    check("rst_misc", {28'd0, stall_o, misalign_o, bus_err_o, reg_w_o}, 0);
    @(negedge clk_i);
    reset_i = 1'b1;

    // ALU pass-through, with a stray ack that must be ignored
    valid_i = 1'b1; alu_result_i = 32'h0000_1234; reg_w_i = 1'b1; reg_d_i = 5'd5; dmem_ack_i = 1'b1;
    #1;
    check("alu_data", data_to_reg_o, 32'h0000_1234);
    check("alu_regw_rd", {26'd0, reg_w_o, reg_d_o}, {26'd0, 1'b1, 5'd5});
    check("alu_stall_req", {30'd0, stall_o, dmem_req_o}, 0);
    @(posedge clk_i); #1;
    check("stray_ack_idle", {30'd0, stall_o, dmem_req_o}, 0);
    @(negedge clk_i);
    valid_i = 1'b0;
    #1;
    check("invalid_regw", 32'(reg_w_o), 0);
    drive_nop();

    // LB 0x103, ack on third BUSY cycle
    do_access(3'b000, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 3,
              ns, nb, qa, qw, qb, qwe, dd, drw, drd, der);
    check("lb_addr", qa, 32'h0000_0100);
    check("lb_be_we", {27'd0, qb, qwe}, {27'd0, 4'b1111, 1'b0});
    check("lb_stall", ns, 4);
    check("lb_data", dd, 32'hFFFF_FF80);
    check("lb_regw_rd", {26'd0, drw, drd}, {26'd0, 1'b1, 5'd9});

    do_access(3'b100, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 3,
              ns, nb, qa, qw, qb, qwe, dd, drw, drd, der);
    check("lbu_data", dd, 32'h0000_0080);

    // LH / LHU upper half, LW
    do_access(3'b001, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 1,
              ns, nb, qa, qw, qb, qwe, dd, drw, drd, der);
    check("lh_data", dd, 32'hFFFF_8001);
    do_access(3'b101, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 2,
              ns, nb, qa, qw, qb, qwe, dd, drw, drd, der);
    check("lhu_data", dd, 32'h0000_8001);
    check("lhu_busy", nb, 2);
    do_access(3'b010, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, 1,
              ns, nb, qa, qw, qb, qwe, dd, drw, drd, der);
    check("lw_data", dd, 32'hDEAD_BEEF);

    // SH 0x202, ack first BUSY cycle
    do_access(3'b001, 1'b0, 1'b1, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 1,
              ns, nb, qa, qw, qb, qwe, dd, drw, drd, der);
    check("sh_we_be", {27'd0, qb, qwe}, {27'd0, 4'b1100, 1'b1});
    check("sh_wdata", qw, 32'hABCD_ABCD);
    check("sh_addr", qa, 32'h0000_0200);
    check("sh_stall", ns, 2);
    check("sh_regw", 32'(drw), 0);

    // SB 0x001, with mem_read also set: must be treated as a store
    do_access(3'b000, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_00CD, 32'h0, 1,
              ns, nb, qa, qw, qb, qwe, dd, drw, drd, der);
    check("sb_we_be", {27'd0, qb, qwe}, {27'd0, 4'b0010, 1'b1});
    check("sb_wdata", qw, 32'hCDCD_CDCD);
    check("sb_regw", 32'(drw), 0);

    // Misaligned LW 0x101
    @(negedge clk_i);
    valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; alu_result_i = 32'h0000_0101;
    reg_w_i = 1'b1; reg_d_i = 5'd3;
    #1;
    check("mis_flag", 32'(misalign_o), 1);
    check("mis_stall_req_regw", {29'd0, stall_o, dmem_req_o, reg_w_o}, 0);
    @(posedge clk_i); #1;
    check("mis_no_req", 32'(dmem_req_o), 0);
    @(negedge clk_i);
    drive_nop();
    #1;
    check("mis_clear", 32'(misalign_o), 0);

    // Reset asserted mid-BUSY with the load still held upstream
    @(negedge clk_i);
    valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; alu_result_i = 32'h0000_0300;
    reg_w_i = 1'b1; reg_d_i = 5'd4;
    @(posedge clk_i); #1;
    check("rstmid_busy", 32'(dmem_req_o), 1);
    @(posedge clk_i); #2;
    reset_i = 1'b0;
    #1;
    check("rstmid_req", 32'(dmem_req_o), 0);
    check("rstmid_stall_regw", {30'd0, stall_o, reg_w_o}, 0);
    @(negedge clk_i);
    drive_nop();
    reset_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b1; alu_result_i = 32'h0000_0777; reg_w_i = 1'b1; reg_d_i = 5'd12;
    #1;
    check("post_rst_alu", {data_to_reg_o[25:0], reg_w_o, reg_d_o}, {26'h777, 1'b1, 5'd12});
    check("post_rst_stall", {30'd0, stall_o, dmem_req_o}, 0);
    @(negedge clk_i);
    drive_nop();

`ifdef MEM_TIMEOUT_EN
    do_access(3'b010, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 32'h1111_1111, 0,
              ns, nb, qa, qw, qb, qwe, dd, drw, drd, der);
    check("to_busy", nb, 8);
    check("to_bus_err", 32'(der), 1);
    check("to_regw", 32'(drw), 0);
    #1;
    check("to_idle", {29'd0, bus_err_o, dmem_req_o, stall_o}, 0);
    // ack on the limit cycle wins
    do_access(3'b010, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 32'h2222_2222, 8,
              ns, nb, qa, qw, qb, qwe, dd, drw, drd, der);
    check("to_ack_wins", {dd[30:0], der}, {31'h2222_2222, 1'b0});
    check("to_ack_regw", 32'(drw), 1);
`else
    #1;
    check("no_timeout_err", 32'(bus_err_o), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- RISC-V pipeline MEM stage: between the EX/MEM pipeline register (upstream) and the MEM/WB register (downstream).
- Performs loads and stores to data memory over a req/ack handshake.
- Aligns and extends load data, stalls the pipeline while an access is outstanding.
- Presents Data_to_reg/Reg_W/Reg_D-style write-back fields to the MEM/WB register.

Parameters:
- TIMEOUT_CYCLES, 16, max BUSY cycles before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-low reset
- valid_i  in  1  EX/MEM slot holds a valid instruction
- alu_result_i  in  32  ALU result / effective address
- store_data_i  in  32  rs2 value for stores
- mem_read_i  in  1  load instruction
- mem_write_i  in  1  store instruction
- funct3_i  in  3  access size/sign
- reg_w_i  in  1  register write enable
- reg_d_i  in  5  destination register
- data_to_reg_o  out  32  write-back data to MEM/WB
- reg_w_o  out  1  write enable to MEM/WB
- reg_d_o  out  5  destination to MEM/WB
- stall_o  out  1  freeze EX/MEM and earlier stages
- misalign_o  out  1  misaligned access flagged (1-cycle)
- bus_err_o  out  1  access aborted by timeout (1-cycle)
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  write strobe
- dmem_addr_o  out  32  word address, bits [1:0] = 0
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  write data, lane-replicated
- dmem_rdata_i  in  32  read data
- dmem_ack_i  in  1  access complete; rdata valid

Behaviour:
- Reset (reset_i=0, async): state IDLE. All registered outputs are 0: dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o, misalign_o, bus_err_o. reg_w_o=0, stall_o=0.
- acc = valid_i & (mem_read_i | mem_write_i).
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Byte is always aligned.
- States: IDLE, BUSY, DONE.
- IDLE, non-memory instruction or !valid_i: zero-latency combinational pass-through.
  - data_to_reg_o=alu_result_i, reg_w_o=reg_w_i&valid_i, reg_d_o=reg_d_i, stall_o=0.
- IDLE, acc & misaligned:
  - No request issued; reg_w_o=0; stall_o=0.
  - misalign_o=1 for exactly that cycle (combinational).
- IDLE, acc & aligned:
  - stall_o=1.
  - At the clock edge, latch: addr, byte enables, replicated wdata, we, funct3, addr[1:0], reg_w, reg_d. Go to BUSY.
- BUSY:
  - dmem_req_o=1 and request fields held stable until ack; stall_o=1; reg_w_o=0.
  - On dmem_ack_i=1, capture the extracted/extended load data, go to DONE.
  - Ack in the first BUSY cycle is legal (1 BUSY cycle).
- DONE:
  - dmem_req_o=0, stall_o=0.
  - data_to_reg_o = captured load data.
  - reg_w_o = latched reg_w & load; stores always give 0.
  - reg_d_o = latched rd.
  - Next state is always IDLE; upstream advances at this edge, so the op is never reissued.
- Store lanes:
  - SB (000): be = 0001<<a[1:0], wdata = {4{byte}}.
  - SH (001): be = a[1] ? 1100 : 0011, wdata = {2{half}}.
  - SW (010): be = 1111.
- Load extraction by latched a[1:0]:
  - LB (000) / LBU (100): sign- / zero-extend the selected byte.
  - LH (001) / LHU (101): sign- / zero-extend the selected half.
  - LW (010): full word.
  - Undefined funct3: treated as LW/SW.
- Load and store both asserted: treated as a store.
- dmem_ack_i outside BUSY is ignored.
- Reset mid-access: BUSY/DONE abort immediately, dmem_req_o drops the same instant, no write-back.

Optional Feature:
- Macro: MEM_TIMEOUT_EN
- Defined:
  - BUSY counter starts at 1 on BUSY entry.
  - If it reaches TIMEOUT_CYCLES with no ack: go to DONE with reg_w_o=0, bus_err_o=1 for that DONE cycle, dmem_req_o dropped.
  - Ack on the same cycle as the limit wins (normal completion).
- Not defined:
  - No counter; BUSY waits indefinitely; bus_err_o tied 0.

Test Plan:
- ALU pass-through: valid_i=1, no mem, alu_result_i=0x00001234, reg_w_i=1, reg_d_i=5 -> same cycle data_to_reg_o=0x00001234, reg_w_o=1, reg_d_o=5, stall_o=0, dmem_req_o=0.
- LB addr 0x00000103, ack on 3rd BUSY cycle, rdata=0x80FF0000 -> dmem_addr_o=0x00000100, be=1111 ignored for reads, stall_o high 4 cycles, DONE data_to_reg_o=0xFFFFFF80, reg_w_o=1; repeat with LBU -> 0x00000080.
- SH addr 0x00000202, store_data_i=0x1234ABCD, ack first BUSY cycle -> dmem_we_o=1, be=1100, wdata=0xABCDABCD, DONE reg_w_o=0, total stall 2 cycles.
- LW addr 0x00000101 -> misalign_o=1 one cycle, dmem_req_o never asserted, reg_w_o=0, stall_o=0.
- reset_i driven low during BUSY (no ack) -> dmem_req_o=0 immediately, stall_o=0. After release, an ALU op passes through normally.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, LW with ack never asserted -> 8 BUSY cycles, then DONE with bus_err_o=1, reg_w_o=0, then IDLE.
